control_decoder_pipe: RTL and testbench

- Next-generation decode/control stage for the pipelined RV32 core.
- Decodes a raw 32-bit instruction into the existing control-signal set and registers the result as the ID/EX control register.
- Adds optional RV32M decode, load-use hazard bubbling, flush, downstream-stall hold, an illegal-instruction flag and a saturating bubble counter.
- Sits between the IF/ID register and the execute stage.

---
 rtl/control_decoder_pipe_if.sv | 47 ++++
 rtl/control_decoder_pipe.sv | 220 ++++++++++++++++++++++
 tb/tb_control_decoder_pipe.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_decoder_pipe_if.sv
// ==== control_decoder_pipe_if : IF/ID-side handshake and ID/EX control-word bundle (rev 1.0) ====
`default_nettype none

interface control_decoder_pipe_if #(
  parameter int ALU_W = 5,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic             flush;
  logic             ex_stall;
  logic             out_valid;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;
  logic             branch;
  logic             jal;
  logic             jalr;
  logic             operand_a;
  logic             operand_b;
  logic [1:0]       mem_to_reg;
  logic [2:0]       imm_sel;
  logic [ALU_W-1:0] alu_control;
  logic [2:0]       funct3_out;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic             illegal;
  logic [CNT_W-1:0] bubble_count;

  modport master (
    output in_valid, instr, flush, ex_stall,
    input  in_ready, out_valid, reg_write, mem_read, mem_write, branch, jal, jalr,
           operand_a, operand_b, mem_to_reg, imm_sel, alu_control, funct3_out,
           rd, rs1, rs2, illegal, bubble_count
  );

  modport slave (
    input  in_valid, instr, flush, ex_stall,
    output in_ready, out_valid, reg_write, mem_read, mem_write, branch, jal, jalr,
           operand_a, operand_b, mem_to_reg, imm_sel, alu_control, funct3_out,
           rd, rs1, rs2, illegal, bubble_count
  );
endinterface

`default_nettype wire

// File: rtl/control_decoder_pipe.sv
// ==== control_decoder_pipe : RV32(I/M) decode into the ID/EX control register (rev 1.0) ====
`default_nettype none

module control_decoder_pipe #(
  parameter int ALU_W = 5,
  parameter bit EN_M  = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  control_decoder_pipe_if.slave bus
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MUL    = 7'b0000001;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
    logic             jal;
    logic             jalr;
    logic             op_a;
    logic             op_b;
    logic [1:0]       mem_to_reg;
    logic [2:0]       imm_sel;
    logic [ALU_W-1:0] alu;
    logic [2:0]       funct3;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             illegal;
  } ctrl_t;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];

  // funct3 -> ALU code for the funct7=0 R-type / I-ALU group
  function automatic logic [4:0] base_alu(input logic [2:0] f3);
    case (f3)
      3'd0:    base_alu = 5'd0;
      3'd1:    base_alu = 5'd2;
      3'd2:    base_alu = 5'd3;
      3'd3:    base_alu = 5'd4;
      3'd4:    base_alu = 5'd5;
      3'd5:    base_alu = 5'd6;
      3'd6:    base_alu = 5'd8;
      default: base_alu = 5'd9;
    endcase
  endfunction

  ctrl_t      dec;
  logic       bad;
  logic       is_lui;
  logic       rs1_used;
  logic       rs2_used;
  logic [4:0] alu_code;

  always_comb begin
    dec      = '0;
    bad      = 1'b0;
    is_lui   = 1'b0;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    alu_code = 5'd0;
    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        rs2_used      = 1'b1;
        if (funct7 == F7_BASE)                        alu_code = base_alu(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'd0)  alu_code = 5'd1;
        else if (funct7 == F7_ALT && funct3 == 3'd5)  alu_code = 5'd7;
        else if (funct7 == F7_MUL && EN_M)            alu_code = {2'b10, funct3};
        else                                          bad = 1'b1;
      end
      OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.op_b      = 1'b1;
        if (funct3 == 3'd1 && funct7 != F7_BASE)      bad = 1'b1;
        else if (funct3 == 3'd5 && funct7 == F7_ALT)  alu_code = 5'd7;
        else if (funct3 == 3'd5 && funct7 != F7_BASE) bad = 1'b1;
        else                                          alu_code = base_alu(funct3);
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.op_b       = 1'b1;
        dec.mem_to_reg = 2'b01;
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.op_b      = 1'b1;
        dec.imm_sel   = 3'b001;
        rs2_used      = 1'b1;
      end
      OP_BRANCH: begin
        dec.branch  = 1'b1;
        dec.op_a    = 1'b1;
        dec.op_b    = 1'b1;
        dec.imm_sel = 3'b010;
        rs2_used    = 1'b1;
      end
      OP_JAL: begin
        dec.jal        = 1'b1;
        dec.reg_write  = 1'b1;
        dec.op_a       = 1'b1;
        dec.op_b       = 1'b1;
        dec.mem_to_reg = 2'b10;
        dec.imm_sel    = 3'b011;
        rs1_used       = 1'b0;
      end
      OP_JALR: begin
        dec.jalr       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.op_b       = 1'b1;
        dec.mem_to_reg = 2'b10;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.op_b      = 1'b1;
        dec.imm_sel   = 3'b100;
        is_lui        = 1'b1;
        rs1_used      = 1'b0;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.op_a      = 1'b1;
        dec.op_b      = 1'b1;
        dec.imm_sel   = 3'b100;
        rs1_used      = 1'b0;
      end
      default: bad = 1'b1;
    endcase
    dec.alu = is_lui ? '1 : ALU_W'(alu_code);
    // Illegal words carry only the raw fields so nothing downstream acts on them
    if (bad) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
    dec.valid  = 1'b1;
    dec.funct3 = funct3;
    dec.rd     = bus.instr[11:7];
    dec.rs1    = bus.instr[19:15];
    dec.rs2    = bus.instr[24:20];
  end

  ctrl_t            word_d, word_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic             hazard;
  logic             in_ready;

  assign hazard = word_q.valid && word_q.mem_read && (word_q.rd != 5'd0) &&
                  ((rs1_used && word_q.rd == bus.instr[19:15]) ||
                   (rs2_used && word_q.rd == bus.instr[24:20]));
  assign in_ready = !bus.ex_stall && !hazard && !bus.flush;

  always_comb begin
    word_d  = word_q;
    count_d = count_q;
    if (bus.flush) begin
      word_d = '0;
    end else if (bus.ex_stall) begin
      word_d = word_q;
    end else if (bus.in_valid && hazard) begin
      word_d = '0;
      if (count_q != '1) count_d = count_q + CNT_W'(1);
    end else if (bus.in_valid && in_ready) begin
      word_d = dec;
    end else begin
      word_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= '0;
      count_q <= '0;
    end else begin
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = word_q.valid;
  assign bus.reg_write    = word_q.reg_write;
  assign bus.mem_read     = word_q.mem_read;
  assign bus.mem_write    = word_q.mem_write;
  assign bus.branch       = word_q.branch;
  assign bus.jal          = word_q.jal;
  assign bus.jalr         = word_q.jalr;
  assign bus.operand_a    = word_q.op_a;
  assign bus.operand_b    = word_q.op_b;
  assign bus.mem_to_reg   = word_q.mem_to_reg;
  assign bus.imm_sel      = word_q.imm_sel;
  assign bus.alu_control  = word_q.alu;
  assign bus.funct3_out   = word_q.funct3;
  assign bus.rd           = word_q.rd;
  assign bus.rs1          = word_q.rs1;
  assign bus.rs2          = word_q.rs2;
  assign bus.illegal      = word_q.illegal;
  assign bus.bubble_count = count_q;
endmodule

`default_nettype wire

// File: tb/tb_control_decoder_pipe.sv
// ==== tb_control_decoder_pipe : two decoder instances (EN_M=1/CNT_W=4, EN_M=0/ALU_W=4) vs reference model (rev 1.0) ====
`default_nettype none

module tb_control_decoder_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr;
  logic        flush;
  logic        ex_stall;
  int          total = 0;
  int          bad = 0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  control_decoder_pipe_if #(.ALU_W(5), .CNT_W(4))  ifa ();
  control_decoder_pipe_if #(.ALU_W(4), .CNT_W(16)) ifb ();

  assign ifa.in_valid = in_valid;
  assign ifa.instr    = instr;
  assign ifa.flush    = flush;
  assign ifa.ex_stall = ex_stall;
  assign ifb.in_valid = in_valid;
  assign ifb.instr    = instr;
  assign ifb.flush    = flush;
  assign ifb.ex_stall = ex_stall;

  control_decoder_pipe #(.ALU_W(5), .EN_M(1'b1), .CNT_W(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  control_decoder_pipe #(.ALU_W(4), .EN_M(1'b0), .CNT_W(16)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  typedef struct packed {
    logic v, rw, mr, mw, br, jal, jalr, oa, ob;
    logic [1:0]  mtr;
    logic [2:0]  imm;
    logic [4:0]  alu;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic        ill;
    logic [15:0] cnt;
  } obs_t;

  obs_t obs_a, obs_b;
  assign obs_a = {ifa.out_valid, ifa.reg_write, ifa.mem_read, ifa.mem_write, ifa.branch, ifa.jal,
                  ifa.jalr, ifa.operand_a, ifa.operand_b, ifa.mem_to_reg, ifa.imm_sel, ifa.alu_control,
                  ifa.funct3_out, ifa.rd, ifa.rs1, ifa.rs2, ifa.illegal, 12'b0, ifa.bubble_count};
  assign obs_b = {ifb.out_valid, ifb.reg_write, ifb.mem_read, ifb.mem_write, ifb.branch, ifb.jal,
                  ifb.jalr, ifb.operand_a, ifb.operand_b, ifb.mem_to_reg, ifb.imm_sel, 1'b0, ifb.alu_control,
                  ifb.funct3_out, ifb.rd, ifb.rs1, ifb.rs2, ifb.illegal, ifb.bubble_count};

  // ALU code of the funct7=0 arithmetic group, indexed by funct3
  int base_alu [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  function automatic obs_t model_dec(input logic [31:0] i, input bit en_m, input int alu_w);
    obs_t o;
    bit   ill;
    int   alu;
    logic [6:0] op, f7;
    logic [2:0] f3;
    o = '0; ill = 0; alu = 0;
    op = i[6:0]; f7 = i[31:25]; f3 = i[14:12];
    case (op)
      7'h33: begin
        o.rw = 1;
        if (f7 == 7'h00)                   alu = base_alu[f3];
        else if (f7 == 7'h20 && f3 == 0)   alu = 1;
        else if (f7 == 7'h20 && f3 == 5)   alu = 7;
        else if (f7 == 7'h01 && en_m)      alu = 16 + int'(f3);
        else                               ill = 1;
      end
      7'h13: begin
        o.rw = 1; o.ob = 1;
        if (f3 == 1 && f7 != 0)            ill = 1;
        else if (f3 == 5 && f7 == 7'h20)   alu = 7;
        else if (f3 == 5 && f7 != 0)       ill = 1;
        else                               alu = base_alu[f3];
      end
      7'h03: begin o.rw = 1; o.mr = 1; o.ob = 1; o.mtr = 2'd1; end
      7'h23: begin o.mw = 1; o.ob = 1; o.imm = 3'd1; end
      7'h63: begin o.br = 1; o.oa = 1; o.ob = 1; o.imm = 3'd2; end
      7'h6F: begin o.jal = 1; o.rw = 1; o.oa = 1; o.ob = 1; o.mtr = 2'd2; o.imm = 3'd3; end
      7'h67: begin o.jalr = 1; o.rw = 1; o.ob = 1; o.mtr = 2'd2; end
      7'h37: begin o.rw = 1; o.ob = 1; o.imm = 3'd4; alu = (1 << alu_w) - 1; end
      7'h17: begin o.rw = 1; o.oa = 1; o.ob = 1; o.imm = 3'd4; end
      default: ill = 1;
    endcase
    if (ill) begin
      o = '0; o.ill = 1;
    end else begin
      o.alu = 5'(alu & ((1 << alu_w) - 1));
    end
    o.v = 1; o.f3 = f3; o.rd = i[11:7]; o.rs1 = i[19:15]; o.rs2 = i[24:20];
    return o;
  endfunction

  // Load-use: previous word is a real load to a nonzero rd that this instruction reads
  function automatic bit model_hz(input obs_t prev, input logic [31:0] i);
    bit reads1, reads2;
    reads1 = !(i[6:0] inside {7'h37, 7'h17, 7'h6F});
    reads2 = (i[6:0] inside {7'h33, 7'h23, 7'h63});
    return prev.v && prev.mr && prev.rd != 0 &&
           ((reads1 && prev.rd == i[19:15]) || (reads2 && prev.rd == i[24:20]));
  endfunction

  obs_t exp_w [2];
  int   cnt_m [2];
  int   cnt_max [2] = '{15, 65535};

  initial begin
    exp_w[0] = '0; exp_w[1] = '0; cnt_m[0] = 0; cnt_m[1] = 0;
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        exp_w[d] = '0; cnt_m[d] = 0;
      end else if (flush) begin
        exp_w[d] = '0;
      end else if (ex_stall) begin
        exp_w[d] = exp_w[d];
      end else if (in_valid && model_hz(exp_w[d], instr)) begin
        exp_w[d] = '0;
        if (cnt_m[d] < cnt_max[d]) cnt_m[d] = cnt_m[d] + 1;
      end else if (in_valid) begin
        exp_w[d] = model_dec(instr, d == 0, (d == 0) ? 5 : 4);
      end else begin
        exp_w[d] = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        obs_t e, g;
        bit   er, gr;
        e = exp_w[d]; e.cnt = 16'(cnt_m[d]);
        g = (d == 0) ? obs_a : obs_b;
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL word%0d t=%0t got=%h exp=%h", d, $time, g, e);
        end
        er = !ex_stall && !flush && !model_hz(exp_w[d], instr);
        gr = (d == 0) ? ifa.in_ready : ifb.in_ready;
        total++;
        if (gr !== er) begin
          bad++;
          $display("FAIL in_ready%0d t=%0t got=%b exp=%b", d, $time, gr, er);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic fl, input logic st);
    in_valid = v; instr = ins; flush = fl; ex_stall = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] f7, op;
    logic [4:0] a, b, c;
    logic [2:0] f3;
    a = 5'($urandom_range(0, 3)); b = 5'($urandom_range(0, 3)); c = 5'($urandom_range(0, 3));
    f3 = 3'($urandom);
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    case ($urandom_range(0, 11))
      0, 10: op = 7'h33;
      1: op = 7'h13;
      2, 3: op = 7'h03;
      4: op = 7'h23;
      5: op = 7'h63;
      6: op = 7'h6F;
      7: op = 7'h67;
      8: op = 7'h37;
      9: op = 7'h17;
      default: op = 7'($urandom);
    endcase
    return {f7, c, b, f3, a, op};
  endfunction

  localparam logic [31:0] I_ADD3  = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] I_LW5   = 32'h0000A283;  // lw x5,0(x1)
  localparam logic [31:0] I_ADD6  = 32'h00228333;  // add x6,x5,x2
  localparam logic [31:0] I_LW0   = 32'h0000A003;  // lw x0,0(x1)
  localparam logic [31:0] I_ADD60 = 32'h00200333;  // add x6,x0,x2
  localparam logic [31:0] I_LUI5  = 32'h123452B7;  // lui x5,0x12345
  localparam logic [31:0] I_MUL   = 32'h023100B3;  // mul x1,x2,x3

  initial begin
    logic acc;
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst_count", 32'(ifa.bubble_count), 32'd0);
    chk("rst_ready", 32'(ifa.in_ready), 32'd1);
    rst = 1'b0;

    drive(1'b1, I_ADD3, 1'b0, 1'b0); tick();
    chk("add_valid", 32'(ifa.out_valid), 32'd1);
    chk("add_rw", 32'(ifa.reg_write), 32'd1);
    chk("add_alu", 32'(ifa.alu_control), 32'd0);
    chk("add_regs", {17'd0, ifa.rd, ifa.rs1, ifa.rs2}, {17'd0, 5'd3, 5'd1, 5'd2});

    drive(1'b1, I_LW5, 1'b0, 1'b0); tick();
    chk("lw_mr", 32'(ifa.mem_read), 32'd1);
    drive(1'b1, I_ADD6, 1'b0, 1'b0); #1;
    chk("ldu_ready", 32'(ifa.in_ready), 32'd0);
    tick();
    chk("ldu_bubble", 32'(ifa.out_valid), 32'd0);
    chk("ldu_count", 32'(ifa.bubble_count), 32'd1);
    tick();
    chk("ldu_accept", {31'd0, ifa.out_valid}, 32'd1);
    chk("ldu_rd", 32'(ifa.rd), 32'd6);

    drive(1'b1, I_LW0, 1'b0, 1'b0); tick();
    drive(1'b1, I_ADD60, 1'b0, 1'b0); #1;
    chk("x0_ready", 32'(ifa.in_ready), 32'd1);
    drive(1'b1, I_LW5, 1'b0, 1'b0); tick();
    drive(1'b1, I_LUI5, 1'b0, 1'b0); #1;
    chk("lui_ready", 32'(ifa.in_ready), 32'd1);
    tick();
    chk("lui_alu", 32'(ifa.alu_control), 32'h1F);
    chk("lui_alu_b", 32'(ifb.alu_control), 32'hF);
    chk("lui_count", 32'(ifa.bubble_count), 32'd1);

    drive(1'b1, I_ADD3, 1'b0, 1'b0); tick();
    drive(1'b1, I_LW5, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_rd", {26'd0, ifa.out_valid, ifa.rd}, {26'd0, 1'b1, 5'd3});
      chk("stall_ready", 32'(ifa.in_ready), 32'd0);
    end
    drive(1'b1, I_LW5, 1'b1, 1'b1); tick();
    chk("stall_flush", 32'(ifa.out_valid), 32'd0);

    drive(1'b1, I_MUL, 1'b0, 1'b0); tick();
    chk("mul_alu", 32'(ifa.alu_control), 32'h10);
    chk("mul_rw", 32'(ifa.reg_write), 32'd1);
    chk("mul_b_illegal", {30'd0, ifb.out_valid, ifb.illegal}, 32'd3);
    chk("mul_b_rw", 32'(ifb.reg_write), 32'd0);

    drive(1'b1, I_LW5, 1'b0, 1'b0); tick();
    drive(1'b1, I_ADD6, 1'b0, 1'b0); rst = 1'b1; tick();
    chk("rst_hz", {ifa.out_valid, ifa.mem_read, 26'd0, ifa.bubble_count}, 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 18; k++) begin
      drive(1'b1, I_LW5, 1'b0, 1'b0); tick();
      drive(1'b1, I_ADD6, 1'b0, 1'b0); tick(); tick();
    end
    chk("sat_count", 32'(ifa.bubble_count), 32'hF);
    chk("sat_count_b", 32'(ifb.bubble_count), 32'd18);
    rst = 1'b1; drive(1'b0, 32'h0, 1'b0, 1'b0); tick();
    chk("sat_rst", 32'(ifa.bubble_count), 32'd0);
    rst = 1'b0;

    acc = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (!(in_valid && !acc)) begin
        in_valid = ($urandom_range(0, 9) < 8);
        instr    = rand_instr();
      end
      flush    = ($urandom_range(0, 19) == 0);
      ex_stall = ($urandom_range(0, 9) == 0);
      rst      = ($urandom_range(0, 199) == 0);
      #1;
      acc = in_valid && ifa.in_ready && !rst;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
